// File: rtl/trigger_pipe_module.sv
// rtl/trigger_pipe_module.sv - elastic WIDTH x DEPTH register pipeline with valid/ready, flush and occupancy
module trigger_pipe_module #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4,
    localparam int OCC_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    input  logic             flush,
    output logic [OCC_W-1:0] occupancy
);

    logic [DEPTH-1:0] v;
    logic [WIDTH-1:0] d [DEPTH];
    logic [DEPTH-1:0] rdy;

    // A stage can load unless it and every stage after it are full while the consumer stalls.
    always_comb begin
        logic full_tail;
        rdy       = '0;
        full_tail = 1'b1;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            full_tail = full_tail & v[i];
            rdy[i]    = out_ready | ~full_tail;
        end
    end

    always_comb begin
        occupancy = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occupancy = occupancy + OCC_W'(v[i]);
        end
    end

    assign in_ready  = rdy[0] & ~flush;
    assign out_valid = v[DEPTH-1];
    assign out_data  = d[DEPTH-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            v <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                d[i] <= '0;
            end
        end else if (flush) begin
            v <= '0;
        end else begin
            if (rdy[0]) begin
                v[0] <= in_valid;
                if (in_valid) begin
                    d[0] <= in_data;
                end
            end
            for (int i = 1; i < DEPTH; i++) begin
                if (rdy[i]) begin
                    v[i] <= v[i-1];
                    if (v[i-1]) begin
                        d[i] <= d[i-1];
                    end
                end
            end
        end
    end

endmodule
